// File: rtl/lrclk_sub_scheduler.sv
// rtl/lrclk_sub_scheduler.sv - one shared saturating subtractor time-multiplexed across channel pairs per LRCLK frame
module lrclk_sub_scheduler #(
  parameter int L    = 24,
  parameter int N_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              next_lrclk_fall,
  input  logic [N_CH*L-1:0] ch_a,
  input  logic [N_CH*L-1:0] ch_b,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              sat_en,
  output logic [N_CH*L-1:0] diff_out,
  output logic [N_CH-1:0]   clip,
  output logic              frame_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
  localparam logic [L-1:0] POS_MAX = {1'b0, {(L-1){1'b1}}};
  localparam logic [L-1:0] NEG_MIN = {1'b1, {(L-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [N_CH*L-1:0]   a_s;
  logic [N_CH*L-1:0]   b_s;
  logic [N_CH-1:0]     en_s;
  logic                sat_s;
  logic [N_CH*L-1:0]   stg_diff;
  logic [N_CH-1:0]     stg_clip;

  logic [L-1:0]        a_cur;
  logic [L-1:0]        b_cur;
  logic [L:0]          d;
  logic                ovf;
  logic [L-1:0]        res;
  logic                en_cur;

  // The single subtract/saturate datapath, fed by the idx-selected snapshot slot.
  // With one guard bit, overflow shows up as the top two bits of d disagreeing.
  always_comb begin
    a_cur  = a_s[int'(idx)*L +: L];
    b_cur  = b_s[int'(idx)*L +: L];
    en_cur = en_s[idx];
    d      = {a_cur[L-1], a_cur} - {b_cur[L-1], b_cur};
    ovf    = d[L] ^ d[L-1];
    res    = d[L-1:0];
    if (sat_s && ovf) begin
      res = d[L] ? NEG_MIN : POS_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      a_s         <= '0;
      b_s         <= '0;
      en_s        <= '0;
      sat_s       <= 1'b0;
      stg_diff    <= '0;
      stg_clip    <= '0;
      diff_out    <= '0;
      clip        <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      case (state)
        IDLE: begin
          if (next_lrclk_fall) begin
            a_s   <= ch_a;
            b_s   <= ch_b;
            en_s  <= ch_en;
            sat_s <= sat_en;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          overrun <= next_lrclk_fall;
          // Disabled channels leave their staging slot holding the last published value.
          if (en_cur) begin
            stg_diff[int'(idx)*L +: L] <= res;
            stg_clip[idx]              <= ovf;
          end
          if (idx == LAST_IDX) begin
            state <= COMMIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        COMMIT: begin
          overrun     <= next_lrclk_fall;
          diff_out    <= stg_diff;
          clip        <= stg_clip;
          frame_valid <= 1'b1;
          busy        <= 1'b0;
          idx         <= '0;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lrclk_sub_scheduler.md
# lrclk_sub_scheduler

Time-multiplexes one shared L-bit signed subtractor across N_CH audio channel pairs within each LRCLK frame. On every `next_lrclk_fall` strobe it snapshots all channel operands, runs them through the shared subtract/saturate stage one channel per clock, and publishes all results at once with a one-cycle `frame_valid` pulse. It sits between the I2S receive deserializers and the transmit serializers. It replaces per-channel subtractor instances in the Subsystem-B audio path.

## Interface
Parameters:
- `L`, 24, sample width in bits (signed two's complement).
- `N_CH`, 4, number of channel pairs; must be ≥ 1.

Ports:
- `clk` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `next_lrclk_fall` in 1: one-cycle strobe marking the start of a frame.
- `ch_a` in N_CH*L: minuend operands; channel k occupies bits [k*L +: L].
- `ch_b` in N_CH*L: subtrahend operands; same packing as `ch_a`.
- `ch_en` in N_CH: per-channel enable; sampled with the operands.
- `sat_en` in 1: 1 = saturate on overflow, 0 = wrap; sampled with the operands.
- `diff_out` out N_CH*L: published results; same packing as `ch_a`.
- `clip` out N_CH: per-channel overflow flag, published with `diff_out`.
- `frame_valid` out 1: one-cycle pulse when `diff_out`/`clip` update.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE).
- `overrun` out 1: one-cycle pulse when a strobe arrives while busy.

## Operation
FSM states are IDLE, RUN and COMMIT. There is a channel index `idx` (clog2(N_CH) bits, minimum 1). A snapshot register holds a_s, b_s, en_s and sat_s. A staging register holds stg_diff and stg_clip.

- **IDLE:**
  - On strobe: snapshot `ch_a`, `ch_b`, `ch_en` and `sat_en`; set idx ← 0; go to RUN.
  - Otherwise stay in IDLE.
- **RUN:** each cycle processes channel idx from the snapshot.
  - Compute d = a_s[idx] − b_s[idx] at L+1 bits, sign-extended.
  - Overflow is defined as d > 2^(L−1)−1 or d < −2^(L−1).
  - If en_s[idx] = 1:
    - stg_clip[idx] ← overflow.
    - stg_diff[idx] ← the clamped value (0x7FF…F or 0x800…0) when sat_s = 1 and overflow; otherwise d[L−1:0] (wrap).
  - If en_s[idx] = 0: staging slot idx is unchanged, so it keeps its last published value.
  - If idx = N_CH−1: go to COMMIT. Otherwise idx ← idx+1.
- **COMMIT:**
  - `diff_out` ← stg_diff and `clip` ← stg_clip.
  - `frame_valid` ← 1.
  - Go to IDLE.
- Inputs `ch_a`, `ch_b`, `ch_en` and `sat_en` are ignored outside the strobe-sampling edge in IDLE. Operand changes mid-frame have no effect.
- A strobe in RUN or COMMIT is dropped:
  - `overrun` pulses for 1 cycle.
  - The current frame completes unaffected.
  - No second frame is queued.
- Only one subtractor and one saturation unit exist. They are shared through an idx-driven operand mux.

## Timing
- Reset (synchronous, dominates every other input in the same cycle):
  - State = IDLE, idx = 0.
  - All snapshot and staging registers = 0.
  - `diff_out` = 0, `clip` = 0.
  - `frame_valid` = 0, `busy` = 0, `overrun` = 0.
- Reset in the middle of a frame abandons the frame. No `frame_valid` is produced, and outputs read 0 from the next cycle.
- Frame timeline (let E0 be the edge that samples the strobe in IDLE):
  - `busy` = 1 after E0.
  - Edges E1…E_N_CH process channels 0…N_CH−1.
  - Edge E(N_CH+1) executes COMMIT. After it, `diff_out` and `clip` hold the new values, `frame_valid` = 1 and `busy` = 0.
  - `frame_valid` returns to 0 after E(N_CH+2).
- Latency from E0 to published results is N_CH+1 clocks (5 with defaults). Minimum strobe spacing without overrun is N_CH+2 clocks.
- A strobe coincident with COMMIT (sampled at E(N_CH+1)) raises `overrun` and is dropped.
- A strobe at E(N_CH+2), when the FSM is back in IDLE, is accepted.
- `diff_out` and `clip` are stable between COMMIT edges.

## Test plan
Defaults L=24, N_CH=4.
- **Basic frame:** a = {100, −5, 0, 0x400000}, b = {30, 10, 0, 1}, ch_en = 0xF, sat_en = 1, single strobe -> `diff_out` = {70, −15, 0, 0x3FFFFF}, `clip` = 0. `frame_valid` is a single pulse 5 clocks after the strobe edge; `busy` is high for exactly 5 cycles.
- **Overflow:**
  - a0 = 0x7FFFFF, b0 = −1: sat_en = 1 -> 0x7FFFFF, clip0 = 1. Same operands with sat_en = 0 -> 0x800000, clip0 = 1.
  - a1 = 0x800000, b1 = 1: sat_en = 1 -> 0x800000. Same operands with sat_en = 0 -> 0x7FFFFF.
- **Masking:** run the basic frame first. Then run a second frame with ch_en = 0b0101 and all operands = 7 -> channels 0 and 2 become 0; channels 1 and 3 keep −15 and 0x3FFFFF, and their clip values are unchanged.
- **Overrun and snapshot:**
  - A strobe 2 clocks after a first strobe -> one `overrun` pulse; the first frame's results are correct; exactly one `frame_valid` is produced.
  - Changing `ch_a` during RUN -> `diff_out` unaffected.
  - A strobe exactly N_CH+2 clocks after the first -> accepted, no `overrun`.
- **Reset mid-frame:** assert `reset` at E2 -> no `frame_valid`, all outputs 0 next cycle. Then strobe with a0 = 9, b0 = 4 -> diff0 = 5 after the normal 5-clock latency.
- **Reset/strobe collision:** `reset` and `next_lrclk_fall` high in the same cycle -> reset wins; `busy` stays 0 and no frame starts.
